// File: rtl/pio_irq_port_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pio_pkg : register map and edge-mode encodings for pio_irq_port     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package pio_pkg;

  localparam logic [2:0] ADDR_OUT  = 3'd0;
  localparam logic [2:0] ADDR_IN   = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage
`default_nettype wire

// File: rtl/pio_irq_port_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pio_irq_port_if : Avalon-MM slave bus signals for pio_irq_port      |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface pio_irq_port_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );

endinterface
`default_nettype wire

// File: rtl/pio_irq_port_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pio_sync_edge : input synchroniser, edge strobe, reset blanking     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] strobe_o
);

  localparam int               CNT_W        = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] BLANK_CYCLES = CNT_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [WIDTH-1:0]                  raw_strobe;
  logic [WIDTH-1:0]                  strobe_q;
  logic [CNT_W-1:0]                  blank_q;

  assign sync_o   = sync_q[SYNC_STAGES-1];
  assign strobe_o = strobe_q;

  generate
    if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
      assign raw_strobe = ~sync_o & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign raw_strobe = sync_o ^ prev_q;
    end else begin : g_rising
      assign raw_strobe = sync_o & ~prev_q;
    end
  endgenerate

  // Strobes are suppressed until the chain and prev have been refilled from
  // live inputs, so a line already high at reset release is not captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      prev_q   <= '0;
      strobe_q <= '0;
      blank_q  <= BLANK_CYCLES;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q   <= sync_o;
      strobe_q <= (blank_q == '0) ? raw_strobe : '0;
      if (blank_q != '0) begin
        blank_q <= blank_q - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pio_irq_port.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pio_irq_port : Avalon-MM PIO with set/clear, edge capture and irq   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module pio_irq_port
  import pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  parameter int          EDGE_TYPE   = EDGE_RISING,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  pio_irq_port_if.slave    bus,
  output logic [WIDTH-1:0] out_port,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] strobe;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             rd_en;
  logic             unused_writedata;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .in_i     (in_port),
    .sync_o   (in_sync),
    .strobe_o (strobe)
  );

  assign wr_en            = bus.chipselect & bus.write;
  assign rd_en            = bus.chipselect & bus.read;
  assign wdata            = bus.writedata[WIDTH-1:0];
  assign unused_writedata = ^bus.writedata;

  // A strobe landing on the same cycle as a W1C wins, so the OR comes last.
  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_en) begin
      case (bus.address)
        ADDR_OUT:  out_d  = wdata;
        ADDR_MASK: mask_d = wdata;
        ADDR_EDGE: edge_d = edge_q & ~wdata;
        ADDR_SET:  out_d  = out_q | wdata;
        ADDR_CLR:  out_d  = out_q & ~wdata;
        default:   ;
      endcase
    end
    edge_d = edge_d | strobe;
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_OUT:  readdata_d = 32'(out_q);
      ADDR_IN:   readdata_d = 32'(in_sync);
      ADDR_MASK: readdata_d = 32'(mask_q);
      ADDR_EDGE: readdata_d = 32'(edge_q);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= OUT_RESET[WIDTH-1:0];
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
    end else begin
      out_q  <= out_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      if (rd_en) begin
        readdata_q <= readdata_d;
      end
    end
  end

  assign bus.readdata = readdata_q;
  assign out_port     = out_q;
  assign irq          = |(edge_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_pio_irq_port.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pio_irq_port : scoreboard testbench for pio_irq_port             |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_pio_irq_port;
  import pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic        irq;
  logic [31:0] sb[$];
  logic [31:0] exp;
  int          checks = 0;
  int          errors = 0;

  pio_irq_port_if bif ();

  pio_irq_port #(
    .WIDTH       (8),
    .OUT_RESET   (32'hA5),
    .EDGE_TYPE   (EDGE_RISING),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bif),
    .out_port (out_port),
    .in_port  (in_port),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    bif.chipselect = 1'b0;
    bif.read       = 1'b0;
    bif.write      = 1'b0;
    bif.address    = 3'd0;
    bif.writedata  = 32'h0;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    bif.chipselect = 1'b1;
    bif.write      = 1'b1;
    bif.address    = addr;
    bif.writedata  = data;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] addr, input logic [31:0] expected);
    sb.push_back(expected);
    bif.chipselect = 1'b1;
    bif.read       = 1'b1;
    bif.address    = addr;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_rw(input logic [2:0] addr, input logic [31:0] data,
                        input logic [31:0] expected);
    sb.push_back(expected);
    bif.chipselect = 1'b1;
    bif.read       = 1'b1;
    bif.write      = 1'b1;
    bif.address    = addr;
    bif.writedata  = data;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_port = 8'h00;
    bif.chipselect = 1'b1;
    bif.read       = 1'b1;
    bif.address    = ADDR_OUT;
    apply_reset(3);
    bus_idle();
    checks++;
    if (bif.readdata !== 32'h0) begin
      errors++; $display("FAIL reset_readdata: got %h expected %h", bif.readdata, 32'h0);
    end
    checks++;
    if (out_port !== 8'hA5) begin
      errors++; $display("FAIL reset_out_port: got %h expected %h", out_port, 8'hA5);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
    bus_read(ADDR_OUT, 32'hA5);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL reset_read_out: got %h expected %h", bif.readdata, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL readdata_hold: got %h expected %h", bif.readdata, exp);
    end
  endtask

  task automatic test_set_clr();
    bus_write(ADDR_OUT, 32'h0F);
    checks++;
    if (out_port !== 8'h0F) begin
      errors++; $display("FAIL out_write: got %h expected %h", out_port, 8'h0F);
    end
    bus_write(ADDR_SET, 32'h30);
    checks++;
    if (out_port !== 8'h3F) begin
      errors++; $display("FAIL out_set: got %h expected %h", out_port, 8'h3F);
    end
    bus_write(ADDR_CLR, 32'h05);
    checks++;
    if (out_port !== 8'h3A) begin
      errors++; $display("FAIL out_clr: got %h expected %h", out_port, 8'h3A);
    end
    bus_read(ADDR_OUT, 32'h3A);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL read_out_after_setclr: got %h expected %h", bif.readdata, exp);
    end
  endtask

  task automatic test_edge_irq();
    bus_write(ADDR_MASK, 32'h01);
    in_port = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL edge_irq_early: got %b expected 0", irq);
    end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL edge_irq_assert: got %b expected 1", irq);
    end
    bus_read(ADDR_IN, 32'h01);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL read_in: got %h expected %h", bif.readdata, exp);
    end
    bus_read(ADDR_EDGE, 32'h01);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL read_edge: got %h expected %h", bif.readdata, exp);
    end
    bus_write(ADDR_MASK, 32'h00);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL mask_clear_irq: got %b expected 0", irq);
    end
    bus_write(ADDR_EDGE, 32'h01);
    bus_read(ADDR_EDGE, 32'h00);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL edge_w1c: got %h expected %h", bif.readdata, exp);
    end
  endtask

  task automatic test_blanking();
    in_port = 8'hFF;
    apply_reset(3);
    bus_write(ADDR_MASK, 32'hFF);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (irq !== 1'b0) begin
        errors++; $display("FAIL blank_irq cycle %0d: got %b expected 0", i, irq);
      end
    end
    bus_read(ADDR_EDGE, 32'h00);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL blank_edge: got %h expected %h", bif.readdata, exp);
    end
  endtask

  task automatic test_w1c_race();
    in_port = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    bus_read(ADDR_EDGE, 32'h00);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL falling_not_captured: got %h expected %h", bif.readdata, exp);
    end
    in_port = 8'h04;
    repeat (3) @(posedge clk);
    #1;
    bus_write(ADDR_EDGE, 32'h04);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL race_irq: got %b expected 1", irq);
    end
    bus_read(ADDR_EDGE, 32'h04);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL race_set_wins: got %h expected %h", bif.readdata, exp);
    end
    bus_write(ADDR_EDGE, 32'h04);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL w1c_irq_deassert: got %b expected 0", irq);
    end
    bus_read(ADDR_EDGE, 32'h00);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL w1c_second_clear: got %h expected %h", bif.readdata, exp);
    end
  endtask

  task automatic test_width_mask();
    bus_write(ADDR_OUT, 32'hFFFF_FFFF);
    checks++;
    if (out_port !== 8'hFF) begin
      errors++; $display("FAIL wide_out_port: got %h expected %h", out_port, 8'hFF);
    end
    bus_read(ADDR_OUT, 32'h0000_00FF);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL wide_read_out: got %h expected %h", bif.readdata, exp);
    end
    bus_read(3'd6, 32'h0);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL reserved_read: got %h expected %h", bif.readdata, exp);
    end
    bus_read(ADDR_SET, 32'h0);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL set_read_zero: got %h expected %h", bif.readdata, exp);
    end
    bus_write(ADDR_IN, 32'hFF);
    bus_read(ADDR_IN, 32'h04);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL in_write_ignored: got %h expected %h", bif.readdata, exp);
    end
    bus_rw(ADDR_OUT, 32'h12, 32'hFF);
    exp = sb.pop_front();
    checks++;
    if (bif.readdata !== exp) begin
      errors++; $display("FAIL rw_pre_write_value: got %h expected %h", bif.readdata, exp);
    end
    checks++;
    if (out_port !== 8'h12) begin
      errors++; $display("FAIL rw_out_port: got %h expected %h", out_port, 8'h12);
    end
  endtask

  initial begin
    reset   = 1'b1;
    in_port = 8'h00;
    bus_idle();
    #1;
    test_reset();
    test_set_clr();
    test_edge_irq();
    test_blanking();
    test_w1c_race();
    test_width_mask();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
